// File: rtl/hive_midi_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hive_midi_tx_arb                                                      |
// | Round-robin MIDI message arbiter: serializes granted messages into    |
// | the TX FIFO with length trimming and timed running-status compression.|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hive_midi_tx_arb #(
  parameter int REQ_N    = 2,
  parameter bit RUN_STAT = 1'b1,
  parameter int RS_TMO   = 2**20
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [REQ_N-1:0]     req_i,
  input  logic [REQ_N*24-1:0]  req_msg_i,
  output logic [REQ_N-1:0]     ack_o,
  input  logic                 rs_clr_i,
  output logic                 wr_o,
  output logic [7:0]           wr_data_o,
  input  logic                 wr_rdy_i,
  output logic                 busy_o,
  output logic                 drop_o
);

  localparam int c_PW = $clog2(REQ_N);
  localparam int c_TW = $clog2(RS_TMO + 1);
  localparam logic [c_TW-1:0] c_TMO = c_TW'(RS_TMO);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STAT = 2'd1,
    S_D1   = 2'd2,
    S_D2   = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_PW-1:0]   r_ptr;
  logic [23:0]       r_msg;
  logic [1:0]        r_len;
  logic [7:0]        r_wr_data;
  logic              r_rs_valid;
  logic [7:0]        r_last_stat;
  logic [c_TW-1:0]   r_timer;

  logic [23:0]       w_msgs [REQ_N];
  logic [c_PW:0]     w_idx;
  logic              w_gnt;
  logic [c_PW-1:0]   w_gnt_idx;
  logic [c_PW-1:0]   w_nxt_ptr;
  logic [23:0]       w_gnt_msg;
  logic [7:0]        w_gnt_stat;
  logic [1:0]        w_gnt_len;
  logic              w_gnt_chan;
  logic              w_skip;
  logic              w_wr;
  logic              w_stat_wr;

  for (genvar k = 0; k < REQ_N; k++) begin : g_msg
    assign w_msgs[k] = req_msg_i[24*k +: 24];
  end

  // Scan downward so the lowest offset from r_ptr is the last (winning) write.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + (c_PW+1)'(i);
      if (w_idx >= (c_PW+1)'(REQ_N)) w_idx = w_idx - (c_PW+1)'(REQ_N);
      if (r_state == S_IDLE && req_i[w_idx[c_PW-1:0]]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_idx[c_PW-1:0];
      end
    end
  end

  always_comb begin
    ack_o = '0;
    if (w_gnt) ack_o[w_gnt_idx] = 1'b1;
  end

  assign w_nxt_ptr  = (w_gnt_idx == c_PW'(REQ_N - 1)) ? '0 : w_gnt_idx + c_PW'(1);
  assign w_gnt_msg  = w_msgs[w_gnt_idx];
  assign w_gnt_stat = w_gnt_msg[23:16];
  assign w_gnt_chan = w_gnt_stat[7] && (w_gnt_stat[7:4] != 4'hF);
  assign w_gnt_len  = !w_gnt_stat[7]                ? 2'd0 :
                      (w_gnt_stat[7:4] == 4'hF)     ? 2'd1 :
                      (w_gnt_stat[7:5] == 3'b110)   ? 2'd2 : 2'd3;
  assign w_skip     = RUN_STAT && w_gnt_chan && r_rs_valid && (w_gnt_stat == r_last_stat);

  assign drop_o     = w_gnt && !w_gnt_stat[7];
  assign busy_o     = (r_state != S_IDLE);
  assign w_wr       = busy_o && wr_rdy_i;
  assign wr_o       = w_wr;
  assign wr_data_o  = r_wr_data;
  assign w_stat_wr  = w_wr && (r_state == S_STAT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_msg     <= '0;
      r_len     <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_ptr <= w_nxt_ptr;
            if (w_gnt_stat[7]) begin
              r_msg <= w_gnt_msg;
              r_len <= w_gnt_len;
              if (w_skip) begin
                r_state   <= S_D1;
                r_wr_data <= w_gnt_msg[15:8];
              end else begin
                r_state   <= S_STAT;
                r_wr_data <= w_gnt_stat;
              end
            end
          end
        end
        S_STAT: begin
          if (w_wr) begin
            if (r_len == 2'd1) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_D1;
              r_wr_data <= r_msg[15:8];
            end
          end
        end
        S_D1: begin
          if (w_wr) begin
            if (r_len == 2'd2) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_D2;
              r_wr_data <= r_msg[7:0];
            end
          end
        end
        S_D2: begin
          if (w_wr) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Realtime statuses (F8-FF) pass through without touching running status.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rs_valid  <= 1'b0;
      r_last_stat <= '0;
      r_timer     <= '0;
    end else begin
      if (w_stat_wr && (r_msg[23:20] != 4'hF)) begin
        r_last_stat <= r_msg[23:16];
        r_rs_valid  <= 1'b1;
        r_timer     <= c_TMO;
      end else if (w_stat_wr && (r_msg[23:19] == 5'b11110)) begin
        r_rs_valid <= 1'b0;
      end else if (r_rs_valid && (r_timer != '0)) begin
        r_timer <= r_timer - c_TW'(1);
        if (r_timer == c_TW'(1)) r_rs_valid <= 1'b0;
      end
      if (rs_clr_i) r_rs_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hive_midi_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hive_midi_tx_arb                                                   |
// | Self-checking bench: vector table plus hand-written corner sequences. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_hive_midi_tx_arb;

  localparam int c_REQ_N  = 2;
  localparam int c_RS_TMO = 16;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic [1:0]  req     = '0;
  logic [47:0] req_msg = '0;
  logic [1:0]  ack;
  logic        rs_clr  = 1'b0;
  logic        wr;
  logic [7:0]  wr_data;
  logic        wr_rdy  = 1'b1;
  logic        busy;
  logic        drop;

  always #5 clk = ~clk;

  hive_midi_tx_arb #(
    .REQ_N    (c_REQ_N),
    .RUN_STAT (1'b1),
    .RS_TMO   (c_RS_TMO)
  ) u_dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req_i     (req),
    .req_msg_i (req_msg),
    .ack_o     (ack),
    .rs_clr_i  (rs_clr),
    .wr_o      (wr),
    .wr_data_o (wr_data),
    .wr_rdy_i  (wr_rdy),
    .busy_o    (busy),
    .drop_o    (drop)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [23:0] msg;
    bit          clr;
    bit          drp;
    int          n;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push3(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    if (n > 0) exp_q.push_back(b0);
    if (n > 1) exp_q.push_back(b1);
    if (n > 2) exp_q.push_back(b2);
  endtask

  // Every FIFO write is matched against the next expected byte.
  always @(negedge clk) begin
    if (rst_n && wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got byte %02h, expected no write", wr_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (wr_data !== e) begin
          errors++;
          $display("FAIL wr_byte: got %02h, expected %02h", wr_data, e);
        end
      end
    end
  end

  task automatic send(input int k, input logic [23:0] m, output bit got, output bit dr);
    int c;
    c   = 0;
    got = 1'b0;
    dr  = 1'b0;
    @(posedge clk); #1;
    req_msg[24*k +: 24] = m;
    req[k] = 1'b1;
    while (!got && c < 100) begin
      @(negedge clk);
      c++;
      if (ack[k]) begin
        got = 1'b1;
        dr  = drop;
      end
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge clk);
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy got 1, expected 0");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, dr;
    int n_acks, last_c, exp_k;

    vecs[0]  = '{24'h903C64, 1'b0, 1'b0, 3, 8'h90, 8'h3C, 8'h64};
    vecs[1]  = '{24'h904050, 1'b0, 1'b0, 2, 8'h40, 8'h50, 8'h00};
    vecs[2]  = '{24'h904050, 1'b1, 1'b0, 3, 8'h90, 8'h40, 8'h50};
    vecs[3]  = '{24'hC507AA, 1'b0, 1'b0, 2, 8'hC5, 8'h07, 8'h00};
    vecs[4]  = '{24'hC51122, 1'b0, 1'b0, 1, 8'h11, 8'h00, 8'h00};
    vecs[5]  = '{24'hF80102, 1'b0, 1'b0, 1, 8'hF8, 8'h00, 8'h00};
    vecs[6]  = '{24'hC53344, 1'b0, 1'b0, 1, 8'h33, 8'h00, 8'h00};
    vecs[7]  = '{24'hF00102, 1'b0, 1'b0, 1, 8'hF0, 8'h00, 8'h00};
    vecs[8]  = '{24'h903C64, 1'b0, 1'b0, 3, 8'h90, 8'h3C, 8'h64};
    vecs[9]  = '{24'h102233, 1'b0, 1'b1, 0, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{24'h900102, 1'b0, 1'b0, 2, 8'h01, 8'h02, 8'h00};
    vecs[11] = '{24'hE30506, 1'b0, 1'b0, 3, 8'hE3, 8'h05, 8'h06};
    vecs[12] = '{24'hB00708, 1'b0, 1'b0, 3, 8'hB0, 8'h07, 8'h08};
    vecs[13] = '{24'hD2090A, 1'b0, 1'b0, 2, 8'hD2, 8'h09, 8'h00};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr", {31'd0, wr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_drop", {31'd0, drop}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Round-robin with both requesters held
    @(posedge clk); #1;
    req_msg = {24'h803C00, 24'h903C64};
    req     = 2'b11;
    n_acks  = 0;
    last_c  = 0;
    exp_k   = 0;
    for (int c = 0; c < 100 && n_acks < 4; c++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        chk("rr_ack", {30'd0, ack}, (exp_k == 0) ? 32'd1 : 32'd2);
        if (n_acks > 0) chk("rr_spacing", c - last_c, 32'd4);
        last_c = c;
        if (exp_k == 0) push3(3, 8'h90, 8'h3C, 8'h64);
        else            push3(3, 8'h80, 8'h3C, 8'h00);
        exp_k = 1 - exp_k;
        n_acks++;
      end
      @(posedge clk); #1;
      if (n_acks == 4) req = 2'b00;
    end
    req = 2'b00;
    chk("rr_grants", n_acks, 32'd4);
    wait_idle();

    // Vector table through requester 0
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].clr) begin
        @(posedge clk); #1 rs_clr = 1'b1;
        @(posedge clk); #1 rs_clr = 1'b0;
      end
      push3(vecs[i].n, vecs[i].b0, vecs[i].b1, vecs[i].b2);
      send(0, vecs[i].msg, got, dr);
      chk($sformatf("vec%0d_ack", i), {31'd0, got}, 32'd1);
      chk($sformatf("vec%0d_drop", i), {31'd0, dr}, {31'd0, vecs[i].drp});
      wait_idle();
    end

    // Running-status timeout
    push3(3, 8'h90, 8'h01, 8'h02);
    send(0, 24'h900102, got, dr);
    chk("tmo_first_ack", {31'd0, got}, 32'd1);
    wait_idle();
    repeat (20) @(posedge clk);
    push3(3, 8'h90, 8'h03, 8'h04);
    send(0, 24'h900304, got, dr);
    chk("tmo_second_ack", {31'd0, got}, 32'd1);
    wait_idle();

    // Backpressure during D1
    push3(3, 8'hA0, 8'h11, 8'h22);
    @(posedge clk); #1;
    req_msg[23:0] = 24'hA01122;
    req[0] = 1'b1;
    @(negedge clk);
    chk("bp_ack", {30'd0, ack}, 32'd1);
    @(posedge clk); #1 req[0] = 1'b0;
    @(negedge clk);
    chk("bp_stat_wr", {31'd0, wr}, 32'd1);
    @(posedge clk); #1 wr_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_wr_low", {31'd0, wr}, 32'd0);
      chk("bp_data_held", {24'd0, wr_data}, 32'h11);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    wr_rdy = 1'b1;
    wait_idle();

    // Reset in the middle of a message
    push3(1, 8'h90, 8'h00, 8'h00);
    @(posedge clk); #1;
    req_msg[23:0] = 24'h903344;
    req[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", {30'd0, ack}, 32'd1);
    @(posedge clk); #1 req[0] = 1'b0;
    @(posedge clk); #1 wr_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data", {24'd0, wr_data}, 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    wr_rdy = 1'b1;
    push3(3, 8'h90, 8'h55, 8'h66);
    send(0, 24'h905566, got, dr);
    chk("post_rst_ack", {31'd0, got}, 32'd1);
    wait_idle();

    // Drop followed by a grant on the very next cycle (ptr now 1)
    push3(3, 8'hB1, 8'h01, 8'h02);
    @(posedge clk); #1;
    req_msg = {24'h102233, 24'hB10102};
    req     = 2'b11;
    @(negedge clk);
    chk("drop_ack", {30'd0, ack}, 32'd2);
    chk("drop_pulse", {31'd0, drop}, 32'd1);
    chk("drop_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_drop_ack", {30'd0, ack}, 32'd1);
    chk("after_drop_pulse", {31'd0, drop}, 32'd0);
    @(posedge clk); #1 req = 2'b00;
    wait_idle();

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
